// File: rtl/ycr1_arb_pkg.sv
// Shared encodings for the core memory-interface arbiter and its response router.
// Grant, status and tag definitions live here so both sides agree on one meaning.
package ycr1_arb_pkg;

    localparam logic [1:0] GRANT0   = 2'b00;
    localparam logic [1:0] GRANT1   = 2'b01;
    localparam logic [1:0] GRANTX   = 2'b11;

    localparam logic [1:0] RESP_OK  = 2'b00;
    localparam logic [1:0] RESP_ERR = 2'b01;

    // One bit is enough to name which of the two requesters issued a command
    typedef logic tag_t;

    function automatic logic isValidGrant(input logic [1:0] grant);
        return (grant == GRANT0) || (grant == GRANT1);
    endfunction

endpackage

// File: rtl/ycr1_tag_fifo.sv
// In-order FIFO of requester tags for commands still waiting on a response.
// Occupancy is tracked by a counter, so full/empty never depend on pointer compares.
module ycr1_tag_fifo
    import ycr1_arb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push,
    input  tag_t          push_tag,
    input  logic          pop,
    output tag_t          head_tag,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count
);

    tag_t          r_mem [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic w_push;
    logic w_pop;

    assign empty    = (r_count == '0);
    assign full     = (r_count == CW'(DEPTH));
    assign count    = r_count;
    assign head_tag = r_mem[r_head];

    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    // Tag storage is left unreset; the counter alone decides what is valid
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail] <= push_tag;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ycr1_resp_router.sv
// Return-path router: remembers which requester won each accepted command and
// steers the in-order responses back to it one cycle later, throttling at capacity.
module ycr1_resp_router
    import ycr1_arb_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [1:0]    gnt,
    input  logic          cmd_req,
    input  logic          cmd_ack,
    input  logic          resp_vld,
    input  logic [DW-1:0] resp_rdata,
    input  logic [1:0]    resp_status,
    output logic          cmd_stall,
    output logic          p0_resp_vld,
    output logic [DW-1:0] p0_rdata,
    output logic [1:0]    p0_status,
    output logic          p1_resp_vld,
    output logic [DW-1:0] p1_rdata,
    output logic [1:0]    p1_status,
    output logic [CW-1:0] outstanding,
    output logic          ord_err
);

    logic          w_accept;
    logic          w_grant_ok;
    logic          w_push;
    logic          w_pop;
    logic          w_err;
    logic          w_empty;
    logic          w_full;
    tag_t          w_head_tag;
    logic [CW-1:0] w_count;

    // Empty is sampled before this cycle's push, so a same-cycle command is never answered
    assign w_grant_ok = isValidGrant(gnt);
    assign w_accept   = cmd_req & cmd_ack & ~w_full;
    assign w_push     = w_accept & w_grant_ok;
    assign w_pop      = resp_vld & ~w_empty;
    assign w_err      = (w_accept & ~w_grant_ok)
                      | (cmd_ack & w_full)
                      | (resp_vld & w_empty);

    assign cmd_stall   = w_full;
    assign outstanding = w_count;

    ycr1_tag_fifo #(
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .push     (w_push),
        .push_tag (gnt[0]),
        .pop      (w_pop),
        .head_tag (w_head_tag),
        .empty    (w_empty),
        .full     (w_full),
        .count    (w_count)
    );

    // Only the valid pulses are one-shot; data and status hold until overwritten
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            p0_resp_vld <= 1'b0;
            p0_rdata    <= '0;
            p0_status   <= '0;
            p1_resp_vld <= 1'b0;
            p1_rdata    <= '0;
            p1_status   <= '0;
            ord_err     <= 1'b0;
        end else begin
            p0_resp_vld <= w_pop & ~w_head_tag;
            p1_resp_vld <= w_pop & w_head_tag;
            if (w_pop && !w_head_tag) begin
                p0_rdata  <= resp_rdata;
                p0_status <= resp_status;
            end
            if (w_pop && w_head_tag) begin
                p1_rdata  <= resp_rdata;
                p1_status <= resp_status;
            end
            if (w_err) begin
                ord_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ycr1_resp_router.sv
// Directed self-checking bench for ycr1_resp_router with hand-computed expectations.
// Inputs change 1 ns after each rising edge; outputs are sampled at that same point.
module tb_ycr1_resp_router;
    import ycr1_arb_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk;
    logic          rstn;
    logic [1:0]    gnt;
    logic          cmd_req;
    logic          cmd_ack;
    logic          resp_vld;
    logic [DW-1:0] resp_rdata;
    logic [1:0]    resp_status;
    logic          cmd_stall;
    logic          p0_resp_vld;
    logic [DW-1:0] p0_rdata;
    logic [1:0]    p0_status;
    logic          p1_resp_vld;
    logic [DW-1:0] p1_rdata;
    logic [1:0]    p1_status;
    logic [CW-1:0] outstanding;
    logic          ord_err;

    int checks = 0;
    int errors = 0;

    ycr1_resp_router #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .gnt         (gnt),
        .cmd_req     (cmd_req),
        .cmd_ack     (cmd_ack),
        .resp_vld    (resp_vld),
        .resp_rdata  (resp_rdata),
        .resp_status (resp_status),
        .cmd_stall   (cmd_stall),
        .p0_resp_vld (p0_resp_vld),
        .p0_rdata    (p0_rdata),
        .p0_status   (p0_status),
        .p1_resp_vld (p1_resp_vld),
        .p1_rdata    (p1_rdata),
        .p1_status   (p1_status),
        .outstanding (outstanding),
        .ord_err     (ord_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, let the edge land, then return the bus to idle
    task automatic applyStimulus(input logic [1:0] g, input logic req, input logic ack,
                                 input logic rv, input logic [31:0] rdata, input logic [1:0] st);
        gnt         = g;
        cmd_req     = req;
        cmd_ack     = ack;
        resp_vld    = rv;
        resp_rdata  = rdata;
        resp_status = st;
        @(posedge clk);
        #1;
        gnt         = GRANTX;
        cmd_req     = 1'b0;
        cmd_ack     = 1'b0;
        resp_vld    = 1'b0;
        resp_rdata  = '0;
        resp_status = RESP_OK;
    endtask

    task automatic doReset();
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic checkPulse(input string tag, input logic e0, input logic e1);
        checkOutput({tag, " p0_resp_vld"}, 32'(p0_resp_vld), 32'(e0));
        checkOutput({tag, " p1_resp_vld"}, 32'(p1_resp_vld), 32'(e1));
    endtask

    initial begin
        rstn        = 1'b0;
        gnt         = GRANTX;
        cmd_req     = 1'b0;
        cmd_ack     = 1'b0;
        resp_vld    = 1'b0;
        resp_rdata  = '0;
        resp_status = RESP_OK;
        #12;
        checkOutput("reset outstanding", 32'(outstanding), 0);
        checkOutput("reset cmd_stall", 32'(cmd_stall), 0);
        checkPulse("reset", 1'b0, 1'b0);
        checkOutput("reset p0_rdata", p0_rdata, 0);
        checkOutput("reset p1_status", 32'(p1_status), 0);
        checkOutput("reset ord_err", 32'(ord_err), 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Basic steering: tags 0,1,0 answered in order
        applyStimulus(GRANT0, 1, 1, 0, 0, RESP_OK);
        applyStimulus(GRANT1, 1, 1, 0, 0, RESP_OK);
        applyStimulus(GRANT0, 1, 1, 0, 0, RESP_OK);
        checkOutput("t1 outstanding 3", 32'(outstanding), 3);
        applyStimulus(GRANTX, 0, 0, 1, 32'hA1, RESP_OK);
        checkPulse("t1 resp A1", 1'b1, 1'b0);
        checkOutput("t1 p0_rdata A1", p0_rdata, 32'hA1);
        checkOutput("t1 outstanding 2", 32'(outstanding), 2);
        applyStimulus(GRANTX, 0, 0, 1, 32'hB2, RESP_ERR);
        checkPulse("t1 resp B2", 1'b0, 1'b1);
        checkOutput("t1 p1_rdata B2", p1_rdata, 32'hB2);
        checkOutput("t1 p1_status ERR", 32'(p1_status), 32'(RESP_ERR));
        checkOutput("t1 p0_rdata hold", p0_rdata, 32'hA1);
        applyStimulus(GRANTX, 0, 0, 1, 32'hC3, RESP_OK);
        checkPulse("t1 resp C3", 1'b1, 1'b0);
        checkOutput("t1 p0_rdata C3", p0_rdata, 32'hC3);
        checkOutput("t1 outstanding 0", 32'(outstanding), 0);
        applyStimulus(GRANTX, 0, 0, 0, 0, RESP_OK);
        checkPulse("t1 idle", 1'b0, 1'b0);
        checkOutput("t1 p0_rdata held", p0_rdata, 32'hC3);
        checkOutput("t1 ord_err", 32'(ord_err), 0);

        // Fill to capacity, overrun, then drain
        applyStimulus(GRANT0, 1, 1, 0, 0, RESP_OK);
        applyStimulus(GRANT1, 1, 1, 0, 0, RESP_OK);
        applyStimulus(GRANT0, 1, 1, 0, 0, RESP_OK);
        checkOutput("t2 stall at 3", 32'(cmd_stall), 0);
        applyStimulus(GRANT1, 1, 1, 0, 0, RESP_OK);
        checkOutput("t2 outstanding 4", 32'(outstanding), 4);
        checkOutput("t2 stall at 4", 32'(cmd_stall), 1);
        applyStimulus(GRANT0, 1, 1, 0, 0, RESP_OK);
        checkOutput("t2 overrun ord_err", 32'(ord_err), 1);
        checkOutput("t2 overrun outstanding", 32'(outstanding), 4);
        applyStimulus(GRANTX, 0, 0, 1, 32'h11, RESP_OK);
        checkOutput("t2 stall released", 32'(cmd_stall), 0);
        checkOutput("t2 outstanding 3", 32'(outstanding), 3);
        checkPulse("t2 resp 11", 1'b1, 1'b0);
        applyStimulus(GRANTX, 0, 0, 1, 32'h22, RESP_OK);
        checkPulse("t2 resp 22", 1'b0, 1'b1);
        applyStimulus(GRANTX, 0, 0, 1, 32'h33, RESP_OK);
        checkPulse("t2 resp 33", 1'b1, 1'b0);
        applyStimulus(GRANTX, 0, 0, 1, 32'h44, RESP_OK);
        checkPulse("t2 resp 44", 1'b0, 1'b1);
        checkOutput("t2 p1_rdata 44", p1_rdata, 32'h44);
        checkOutput("t2 drained", 32'(outstanding), 0);

        // Push and pop in the same cycle
        doReset();
        applyStimulus(GRANT0, 1, 1, 0, 0, RESP_OK);
        applyStimulus(GRANT1, 1, 1, 0, 0, RESP_OK);
        applyStimulus(GRANT1, 1, 1, 1, 32'h55, RESP_OK);
        checkOutput("t3 outstanding held", 32'(outstanding), 2);
        checkPulse("t3 resp 55", 1'b1, 1'b0);
        checkOutput("t3 p0_rdata 55", p0_rdata, 32'h55);
        applyStimulus(GRANTX, 0, 0, 1, 32'h66, RESP_OK);
        checkPulse("t3 resp 66", 1'b0, 1'b1);
        applyStimulus(GRANTX, 0, 0, 1, 32'h77, RESP_ERR);
        checkPulse("t3 resp 77", 1'b0, 1'b1);
        checkOutput("t3 p1_rdata 77", p1_rdata, 32'h77);
        checkOutput("t3 outstanding 0", 32'(outstanding), 0);
        checkOutput("t3 ord_err", 32'(ord_err), 0);

        // Response with nothing outstanding
        applyStimulus(GRANTX, 0, 0, 1, 32'hDEAD, RESP_OK);
        checkPulse("t4 empty resp", 1'b0, 1'b0);
        checkOutput("t4 ord_err set", 32'(ord_err), 1);
        checkOutput("t4 p0_rdata hold", p0_rdata, 32'h55);
        checkOutput("t4 outstanding 0", 32'(outstanding), 0);
        applyStimulus(GRANT0, 1, 1, 0, 0, RESP_OK);
        applyStimulus(GRANTX, 0, 0, 1, 32'h88, RESP_OK);
        checkPulse("t4 good resp", 1'b1, 1'b0);
        checkOutput("t4 ord_err sticky", 32'(ord_err), 1);

        // Accept with no grant, and empty pop racing a push
        doReset();
        checkOutput("t5 ord_err cleared", 32'(ord_err), 0);
        applyStimulus(GRANTX, 1, 1, 0, 0, RESP_OK);
        checkOutput("t5 no push", 32'(outstanding), 0);
        checkOutput("t5 ord_err", 32'(ord_err), 1);
        checkOutput("t5 stall", 32'(cmd_stall), 0);
        doReset();
        applyStimulus(GRANT1, 1, 1, 1, 32'h99, RESP_OK);
        checkPulse("t5 race", 1'b0, 1'b0);
        checkOutput("t5 race outstanding", 32'(outstanding), 1);
        checkOutput("t5 race ord_err", 32'(ord_err), 1);

        // Asynchronous reset mid-stream
        doReset();
        applyStimulus(GRANT0, 1, 1, 0, 0, RESP_OK);
        applyStimulus(GRANT1, 1, 1, 0, 0, RESP_OK);
        applyStimulus(GRANT0, 1, 1, 0, 0, RESP_OK);
        applyStimulus(GRANTX, 0, 0, 1, 32'hAB, RESP_ERR);
        checkPulse("t6 before reset", 1'b1, 1'b0);
        rstn = 1'b0;
        #1;
        checkOutput("t6 async outstanding", 32'(outstanding), 0);
        checkPulse("t6 async", 1'b0, 1'b0);
        checkOutput("t6 async p0_rdata", p0_rdata, 0);
        checkOutput("t6 async p0_status", 32'(p0_status), 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        applyStimulus(GRANTX, 0, 0, 1, 32'h123, RESP_OK);
        checkPulse("t6 post reset", 1'b0, 1'b0);
        checkOutput("t6 outstanding", 32'(outstanding), 0);
        checkOutput("t6 ord_err", 32'(ord_err), 1);
        applyStimulus(GRANTX, 0, 0, 0, 0, RESP_OK);
        checkPulse("t6 quiet", 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
